// File: rtl/mem_resp_pkg.sv
// -----------------------------------------------------------------------------
// mem_resp_pkg
// Shared types and helpers for the PicoRV32 native-bus memory responder.
//   mem_resp_state_t : responder FSM states (IDLE, WAIT, RESP)
//   MEM_STRB_READ    : write-strobe pattern that marks a read request
//   in_range()       : 32-bit unsigned window check of a byte address
// -----------------------------------------------------------------------------
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

    localparam logic [3:0] MEM_STRB_READ = 4'b0000;

    // The subtraction wraps, so addresses below base land far above the
    // window limit and are rejected by the same unsigned compare.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] words);
        logic [31:0] offset;
        logic [31:0] limit;
        offset = addr - base;
        limit  = words << 2;
        return (offset < limit);
    endfunction

endpackage

// File: rtl/mem_responder_byte_ram.sv
// -----------------------------------------------------------------------------
// byte_ram
// Single-port word memory with four independently writable byte lanes.
// The write is synchronous; the read port is combinational so the responder
// can register the word at the same edge that commits the transaction.
// Ports:
//   clk   : clock
//   we    : per-lane write enables (lane i = bits 8i+7:8i)
//   addr  : word index shared by read and write
//   wdata : write data
//   rdata : word currently addressed
// -----------------------------------------------------------------------------
module byte_ram #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [3:0][7:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                r_mem[addr][i] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = r_mem[addr];

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Target side of the PicoRV32 native memory interface: word-organised on-chip
// memory with byte-strobe writes, a fixed number of wait states and a sticky
// bus-error report for out-of-range or misaligned accesses.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   mem_valid    : initiator request
//   mem_instr    : request is an instruction fetch (latched, informational)
//   mem_addr     : byte address
//   mem_wdata    : write data
//   mem_wstrb    : byte write strobes, 4'b0000 = read
//   mem_ready    : one-cycle completion pulse
//   mem_rdata    : read data, non-zero only while mem_ready is high
//   err          : sticky bus-error flag
//   err_addr     : address of the first erroring access
// -----------------------------------------------------------------------------
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        err,
    output logic [31:0] err_addr
);

    localparam int         AW        = $clog2(MEM_WORDS);
    localparam logic [3:0] CNT_INIT  = 4'(WAIT_CYCLES);
    localparam logic [31:0] WORDS_32 = 32'(MEM_WORDS);

    mem_resp_state_t r_state;
    mem_resp_state_t w_next;

    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_instr;

    logic        r_ready;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_err_addr;

    logic        w_accept;
    logic        w_commit;
    logic        w_cnt_dec;

    logic [31:0] w_c_addr;
    logic [31:0] w_c_wdata;
    logic [3:0]  w_c_wstrb;
    logic [31:0] w_off;
    logic [AW-1:0] w_idx;
    logic        w_ok;
    logic        w_is_read;
    logic [3:0]  w_we;
    logic [31:0] w_ram_rdata;
    logic        w_unused_ok;

    // Next-state logic. With zero wait states the accepting edge is also the
    // commit edge, so IDLE can jump straight to RESP.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_commit  = 1'b0;
        w_cnt_dec = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_valid) begin
                    w_accept = 1'b1;
                    if (CNT_INIT == 4'd0) begin
                        w_next   = RESP;
                        w_commit = 1'b1;
                    end else begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!mem_valid) begin
                    w_next = IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_next   = RESP;
                    w_commit = 1'b1;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // A commit out of IDLE uses the live bus; a commit out of WAIT uses the
    // copy latched at acceptance, so later bus changes have no effect.
    assign w_c_addr  = (r_state == IDLE) ? mem_addr  : r_addr;
    assign w_c_wdata = (r_state == IDLE) ? mem_wdata : r_wdata;
    assign w_c_wstrb = (r_state == IDLE) ? mem_wstrb : r_wstrb;

    assign w_off     = w_c_addr - BASE_ADDR;
    assign w_idx     = w_off[AW+1:2];
    assign w_ok      = in_range(w_c_addr, BASE_ADDR, WORDS_32) && (w_c_addr[1:0] == 2'b00);
    assign w_is_read = (w_c_wstrb == MEM_STRB_READ);

    // Reset masks the write so a transaction in flight leaves memory intact.
    assign w_we = (w_commit && w_ok && reset_n) ? w_c_wstrb : 4'b0000;

    assign w_unused_ok = ^{r_instr, w_off};

    byte_ram #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .addr  (w_idx),
        .wdata (w_c_wdata),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_ready    <= 1'b0;
            r_rdata    <= 32'h0000_0000;
            r_err      <= 1'b0;
            r_err_addr <= 32'h0000_0000;
        end else begin
            r_state <= w_next;
            r_ready <= w_commit;
            // Writes and erroring accesses return zero; outside the ready
            // cycle the data bus also idles at zero.
            r_rdata <= (w_commit && w_ok && w_is_read) ? w_ram_rdata : 32'h0000_0000;

            if (w_accept) begin
                r_cnt <= CNT_INIT;
            end else if (w_cnt_dec) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_commit && !w_ok) begin
                r_err <= 1'b1;
                if (!r_err) begin
                    r_err_addr <= w_c_addr;
                end
            end
        end
    end

    // Request fields carry no reset; they are only consumed after acceptance.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
            r_instr <= mem_instr;
        end
    end

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;
    assign err       = r_err;
    assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Two responders (2 wait states and 0 wait states) driven by a PicoRV32-style
// initiator. Every request pushes its expected response (data, ready cycle,
// error state) into a per-instance queue; a negedge monitor pops and compares
// whenever mem_ready is seen, and checks that mem_rdata idles at zero.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    localparam int MW = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        valid    [2];
    logic        instr    [2];
    logic [31:0] addr     [2];
    logic [31:0] wdata    [2];
    logic [3:0]  wstrb    [2];
    logic        ready    [2];
    logic [31:0] rdata    [2];
    logic        err      [2];
    logic [31:0] err_addr [2];

    mem_responder #(.MEM_WORDS(MW), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .reset_n(reset_n),
        .mem_valid(valid[0]), .mem_instr(instr[0]), .mem_addr(addr[0]),
        .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
        .mem_ready(ready[0]), .mem_rdata(rdata[0]),
        .err(err[0]), .err_addr(err_addr[0])
    );

    mem_responder #(.MEM_WORDS(MW), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .reset_n(reset_n),
        .mem_valid(valid[1]), .mem_instr(instr[1]), .mem_addr(addr[1]),
        .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
        .mem_ready(ready[1]), .mem_rdata(rdata[1]),
        .err(err[1]), .err_addr(err_addr[1])
    );

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
        logic        err;
        logic [31:0] eaddr;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model: flat word array plus sticky error state per instance.
    logic [31:0] mmem   [2][MW];
    logic        merr   [2];
    logic [31:0] meaddr [2];

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wc(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_one(input int d);
        exp_t e;
        bit   empty;
        empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (ready[d] === 1'b1) begin
            if (empty) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ready dut%0d: got ready=1 expected ready=0 (cycle %0d)", d, cyc);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check($sformatf("ready_cycle dut%0d", d), 32'(cyc), 32'(e.cyc));
                check($sformatf("rdata dut%0d", d), rdata[d], e.rdata);
                check($sformatf("err dut%0d", d), {31'b0, err[d]}, {31'b0, e.err});
                check($sformatf("err_addr dut%0d", d), err_addr[d], e.eaddr);
            end
        end else begin
            check($sformatf("idle_ready dut%0d", d), {31'b0, ready[d]}, 32'h0);
            check($sformatf("idle_rdata dut%0d", d), rdata[d], 32'h0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) mon_one(d);
        end
    end

    // Apply the request to the model and queue the expected response.
    task automatic model_push(input int d, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] st);
        exp_t        e;
        logic [31:0] off;
        bit          bad;
        int          idx;
        off = a;
        bad = (off >= 32'(MW * 4)) || (a % 4 != 0);
        e.rdata = 32'h0;
        if (bad) begin
            if (!merr[d]) meaddr[d] = a;
            merr[d] = 1'b1;
        end else begin
            idx = int'(off / 4);
            if (st == 4'b0000) begin
                e.rdata = mmem[d][idx];
            end else begin
                for (int i = 0; i < 4; i++)
                    if (st[i]) mmem[d][idx][8*i +: 8] = wd[8*i +: 8];
            end
        end
        e.cyc   = cyc + wc(d);
        e.err   = merr[d];
        e.eaddr = meaddr[d];
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic wait_ready(input int d);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (ready[d] !== 1'b1 && k < 40);
        if (ready[d] !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL ready_timeout dut%0d: got no ready expected ready within 40 cycles", d);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that ends
    // the ready cycle, with mem_valid low.
    task automatic txn(input int d, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input logic ins);
        valid[d] = 1'b1;
        addr[d]  = a;
        wdata[d] = wd;
        wstrb[d] = st;
        instr[d] = ins;
        @(posedge clk); #1;
        model_push(d, a, wd, st);
        if (wc(d) > 0) begin
            addr[d]  = $urandom;
            wdata[d] = $urandom;
            wstrb[d] = 4'($urandom);
        end
        wait_ready(d);
        @(posedge clk); #1;
        valid[d] = 1'b0;
        instr[d] = 1'b0;
    endtask

    task automatic abort_txn(input int d, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] st);
        valid[d] = 1'b1;
        addr[d]  = a;
        wdata[d] = wd;
        wstrb[d] = st;
        @(posedge clk); #1;
        valid[d] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s ready dut%0d", tag, d), {31'b0, ready[d]}, 32'h0);
            check($sformatf("%s rdata dut%0d", tag, d), rdata[d], 32'h0);
            check($sformatf("%s err dut%0d", tag, d), {31'b0, err[d]}, 32'h0);
            check($sformatf("%s err_addr dut%0d", tag, d), err_addr[d], 32'h0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  st;
        int          d;
        int          r;

        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0; instr[i] = 1'b0; addr[i] = 32'h0;
            wdata[i] = 32'h0; wstrb[i] = 4'h0;
            merr[i] = 1'b0; meaddr[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Preload the low 64 words of both memories.
        for (int i = 0; i < 2; i++)
            for (int w = 0; w < 64; w++)
                txn(i, 32'(w * 4), $urandom, 4'hF, 1'b0);

        // Full-word write then read back with 2 wait states.
        txn(0, 32'h10, 32'hCAFEBABE, 4'hF, 1'b0);
        txn(0, 32'h10, 32'h0, 4'h0, 1'b0);

        // Byte strobes: expect 0x11BB33DD on read back.
        txn(0, 32'h20, 32'h11223344, 4'hF, 1'b0);
        txn(0, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
        txn(0, 32'h20, 32'h0, 4'h0, 1'b0);

        // Aborted write must leave the word at zero.
        txn(0, 32'h30, 32'h0, 4'hF, 1'b0);
        abort_txn(0, 32'h30, 32'hFFFFFFFF, 4'hF);
        txn(0, 32'h30, 32'h0, 4'h0, 1'b0);

        // Out of range, then misaligned: err_addr keeps the first address.
        txn(0, 32'h0000_1000, 32'h0, 4'h0, 1'b0);
        txn(0, 32'h0000_0022, 32'h0, 4'h0, 1'b0);
        check("sticky err_addr dut0", err_addr[0], 32'h0000_1000);

        // Reset lands on the edge that would have committed the write.
        txn(0, 32'h40, 32'h12345678, 4'hF, 1'b0);
        valid[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'hDEADBEEF; wstrb[0] = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n  = 1'b1;
        valid[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            merr[i] = 1'b0;
            meaddr[i] = 32'h0;
        end
        check_reset_outputs("mid_reset");
        repeat (4) @(posedge clk);
        #1;
        txn(0, 32'h40, 32'h0, 4'h0, 1'b0);

        // Zero wait states: eight back-to-back instruction fetches.
        for (int i = 0; i < 8; i++)
            txn(1, 32'(i * 4), 32'h0, 4'h0, 1'b1);

        // Randomised traffic on both instances.
        for (int n = 0; n < 240; n++) begin
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 11));
            if (r == 0)      a = 32'h1000 + 32'($urandom_range(0, 4000)) * 4;
            else if (r == 1) a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
            else             a = 32'($urandom_range(0, 63)) * 4;
            st = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            txn(d, a, $urandom, st, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        #1;
        check("pending dut0", 32'(q0.size()), 32'h0);
        check("pending dut1", 32'(q1.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
